ras_resolve_unit: RTL

- Execute-side counterpart of the return_address_stack.
- Holds every call/return prediction issued at fetch in an in-order queue.
- Checks each return's predicted target against the target resolved in EX.
- On mismatch, emits a redirect plus a TOS repair that restores the RAS pointer snapshot taken before the bad pop.

---
 rtl/ras_resolve_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ras_resolve_unit.sv
// ras_resolve_unit
//
// Execute-side partner of the return address stack. Each call/return
// prediction made at fetch is queued in order. When EX resolves the oldest
// entry, a return whose predicted target differs from the resolved target
// triggers a redirect and a RAS TOS repair. The repair restores the pointer
// snapshot that was taken before the bad pop. A mismatch also squashes every
// younger queued prediction.
//
// Parameters:
//   INDEX  - log2 of RAS depth; width of the TOS snapshots
//   QDEPTH - in-flight prediction queue entries (power of two, >= 2)
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   stall           - freezes enqueue and dequeue
//   flush           - external squash; empties the queue and wins over everything else
//   pred_*          - fetch-side prediction handshake (valid/ready, is_ret, target, tos)
//   res_valid/target- EX resolution of the oldest outstanding entry
//   mispredict      - registered pulse, with redirect_pc
//   repair_valid    - registered pulse, with repair_tos
//   occupancy       - current entry count
//   err_underflow   - sticky: a resolution arrived while the queue was empty
//
// Optional feature (macro RAS_RESOLVE_STATS_EN):
//   ret_count      - dequeued return entries
//   mispred_count  - detected mismatches
//   Both counters are 32-bit and wrap.

module ras_resolve_unit #(
    parameter int unsigned INDEX  = 3,
    parameter int unsigned QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     pred_valid,
    output logic                     pred_ready,
    input  logic                     pred_is_ret,
    input  logic [31:0]              pred_target,
    input  logic [INDEX-1:0]         pred_tos,
    input  logic                     res_valid,
    input  logic [31:0]              res_target,
    output logic                     mispredict,
    output logic [31:0]              redirect_pc,
    output logic                     repair_valid,
    output logic [INDEX-1:0]         repair_tos,
    output logic [$clog2(QDEPTH):0]  occupancy,
    output logic                     err_underflow
`ifdef RAS_RESOLVE_STATS_EN
    ,
    output logic [31:0]              ret_count,
    output logic [31:0]              mispred_count
`endif
);

    localparam int unsigned PtrW = $clog2(QDEPTH);
    localparam int unsigned CntW = PtrW + 1;

    // Queue storage
    logic             q_is_ret [QDEPTH];
    logic [31:0]      q_target [QDEPTH];
    logic [INDEX-1:0] q_tos    [QDEPTH];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic             mispredict_q;
    logic [31:0]      redirect_pc_q;
    logic [INDEX-1:0] repair_tos_q;
    logic             err_underflow_q;

    logic full, empty, enq, res_ok, deq, underflow, mismatch, squash;
    logic head_is_ret;
    logic [31:0] head_target;
    logic [INDEX-1:0] head_tos;

    always_comb begin
        full        = (count_q == CntW'(QDEPTH));
        empty       = (count_q == '0);
        head_is_ret = q_is_ret[head_q];
        head_target = q_target[head_q];
        head_tos    = q_tos[head_q];

        // pred_ready looks only at the registered count. A same-cycle dequeue
        // therefore never opens a slot while the queue is full.
        pred_ready = !full && !stall;
        enq        = pred_valid && pred_ready && !flush;
        res_ok     = res_valid && !stall && !flush;
        deq        = res_ok && !empty;
        underflow  = res_ok && empty;
        mismatch   = deq && head_is_ret && (res_target != head_target);
        squash     = flush || mismatch;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (squash) begin
            // A mismatch squashes all younger entries, including one arriving now.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PtrW'(1);
            if (deq) head_d = head_q + PtrW'(1);
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= '0;
            repair_tos_q    <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            mispredict_q <= mismatch;
            if (mismatch) begin
                redirect_pc_q <= res_target;
                repair_tos_q  <= head_tos;
            end
            if (underflow) err_underflow_q <= 1'b1;
        end
    end

    // The slot write may happen in a mismatch cycle. It is harmless because the
    // pointers are reset on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_is_ret[i] <= 1'b0;
                q_target[i] <= '0;
                q_tos[i]    <= '0;
            end
        end else if (enq) begin
            q_is_ret[tail_q] <= pred_is_ret;
            q_target[tail_q] <= pred_target;
            q_tos[tail_q]    <= pred_tos;
        end
    end

    assign mispredict    = mispredict_q;
    assign repair_valid  = mispredict_q;
    assign redirect_pc   = redirect_pc_q;
    assign repair_tos    = repair_tos_q;
    assign occupancy     = count_q;
    assign err_underflow = err_underflow_q;

`ifdef RAS_RESOLVE_STATS_EN
    logic [31:0] ret_count_q, mispred_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_count_q     <= '0;
            mispred_count_q <= '0;
        end else begin
            if (deq && head_is_ret) ret_count_q <= ret_count_q + 32'd1;
            if (mismatch) mispred_count_q <= mispred_count_q + 32'd1;
        end
    end

    assign ret_count     = ret_count_q;
    assign mispred_count = mispred_count_q;
`endif

endmodule
